// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller: command encodings,
// arbiter state encoding and the default refresh interval.
package sdram_pkg;

    // Refresh interval in sclk cycles: 64 ms / 8192 rows at 100 MHz.
    localparam int REF_CYCLES_DEF = 780;

    // Commands are {cs_n, ras_n, cas_n, we_n}.
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_ACT  = 4'b0011;
    localparam logic [3:0] CMD_WR   = 4'b0100;
    localparam logic [3:0] CMD_RD   = 4'b0101;
    localparam logic [3:0] CMD_MRS  = 4'b0000;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } arb_state_e;

endpackage

// File: rtl/sdram_ref_timer.sv
// Periodic refresh timer. Counts once init has completed and raises
// ref_pend on every wrap. A single pending flag is kept, so wraps that
// arrive while a refresh is already pending are merged.
module sdram_ref_timer
    import sdram_pkg::*;
#(
    parameter int REF_CYCLES = REF_CYCLES_DEF
) (
    input  logic sclk,
    input  logic s_rst,
    input  logic init_done,
    input  logic clr,
    output logic ref_pend
);

    localparam int CW = $clog2(REF_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          wrap;

    // Next count and pending flag; a clear on AREF entry beats a same-cycle wrap.
    always_comb begin
        wrap   = init_done && (cnt_q == CW'(REF_CYCLES - 1));
        cnt_d  = cnt_q;
        pend_d = pend_q;
        if (init_done) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
        if (clr) begin
            pend_d = 1'b0;
        end else if (wrap) begin
            pend_d = 1'b1;
        end
    end

    // Counter and pending flag registers.
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign ref_pend = pend_q;

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM command bus arbiter. Grants the single command/address bus to
// init, refresh, write and read in turn (refresh > write > read) and
// emits a one-cycle registered grant pulse on entry to each owner state.
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int REF_CYCLES = REF_CYCLES_DEF
) (
    input  logic        sclk,
    input  logic        s_rst,
    input  logic        init_done,
    input  logic [3:0]  init_cmd,
    input  logic [12:0] init_addr,
    output logic        aref_en,
    input  logic        aref_end,
    input  logic [3:0]  aref_cmd,
    input  logic [12:0] aref_addr,
    input  logic        wr_req,
    output logic        wr_en,
    input  logic        wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [12:0] wr_addr,
    input  logic [1:0]  wr_bank,
    input  logic        rd_req,
    output logic        rd_en,
    input  logic        rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [12:0] rd_addr,
    input  logic [1:0]  rd_bank,
    output logic        ref_pend,
    output logic [3:0]  sdram_cmd,
    output logic [12:0] sdram_addr,
    output logic [1:0]  sdram_bank
);

    arb_state_e state_q, state_d;
    logic       aref_en_q, wr_en_q, rd_en_q;
    logic       enter_aref;

    sdram_ref_timer #(.REF_CYCLES(REF_CYCLES)) u_ref_timer (
        .sclk      (sclk),
        .s_rst     (s_rst),
        .init_done (init_done),
        .clr       (enter_aref),
        .ref_pend  (ref_pend)
    );

    // Next-state logic; requests are only looked at while idle in ARBIT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:  if (init_done) state_d = ST_ARBIT;
            ST_ARBIT: begin
                if (ref_pend)     state_d = ST_AREF;
                else if (wr_req)  state_d = ST_WRITE;
                else if (rd_req)  state_d = ST_READ;
            end
            ST_AREF:  if (aref_end) state_d = ST_ARBIT;
            ST_WRITE: if (wr_end)   state_d = ST_ARBIT;
            ST_READ:  if (rd_end)   state_d = ST_ARBIT;
            default:  state_d = ST_INIT;
        endcase
    end

    assign enter_aref = (state_q != ST_AREF) && (state_d == ST_AREF);

    // State register and grant pulses, high on the first cycle in each owner state.
    always_ff @(posedge sclk) begin
        if (s_rst) begin
            state_q   <= ST_INIT;
            aref_en_q <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            aref_en_q <= enter_aref;
            wr_en_q   <= (state_q != ST_WRITE) && (state_d == ST_WRITE);
            rd_en_q   <= (state_q != ST_READ)  && (state_d == ST_READ);
        end
    end

    assign aref_en = aref_en_q;
    assign wr_en   = wr_en_q;
    assign rd_en   = rd_en_q;

    // Bus mux driven straight from the state register; sources are already registered.
    always_comb begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = '0;
        sdram_bank = '0;
        case (state_q)
            ST_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_addr = aref_addr;
            end
            ST_WRITE: begin
                sdram_cmd  = wr_cmd;
                sdram_addr = wr_addr;
                sdram_bank = wr_bank;
            end
            ST_READ: begin
                sdram_cmd  = rd_cmd;
                sdram_addr = rd_addr;
                sdram_bank = rd_bank;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sdram_arbit.sv
// Bench for sdram_arbit: a bus-ownership model checked every cycle,
// directed scenarios with hand-computed expectations, then random traffic.
module tb_sdram_arbit;

    localparam int RC = 780;
    localparam int O_INIT = 0, O_IDLE = 1, O_REF = 2, O_WR = 3, O_RD = 4;

    logic        sclk = 1'b0, s_rst = 1'b1, init_done = 1'b0;
    logic [3:0]  init_cmd = 4'b0111, aref_cmd = 4'b0001, wr_cmd = 4'b0100, rd_cmd = 4'b0101;
    logic [12:0] init_addr = '0, aref_addr = '0, wr_addr = '0, rd_addr = '0;
    logic [1:0]  wr_bank = '0, rd_bank = '0;
    logic        aref_end = 1'b0, wr_req = 1'b0, wr_end = 1'b0, rd_req = 1'b0, rd_end = 1'b0;
    logic        aref_en, wr_en, rd_en, ref_pend;
    logic [3:0]  sdram_cmd;
    logic [12:0] sdram_addr;
    logic [1:0]  sdram_bank;

    always #5 sclk = ~sclk;

    sdram_arbit #(.REF_CYCLES(RC)) dut (
        .sclk(sclk), .s_rst(s_rst), .init_done(init_done),
        .init_cmd(init_cmd), .init_addr(init_addr),
        .aref_en(aref_en), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_addr(aref_addr),
        .wr_req(wr_req), .wr_en(wr_en), .wr_end(wr_end), .wr_cmd(wr_cmd),
        .wr_addr(wr_addr), .wr_bank(wr_bank),
        .rd_req(rd_req), .rd_en(rd_en), .rd_end(rd_end), .rd_cmd(rd_cmd),
        .rd_addr(rd_addr), .rd_bank(rd_bank),
        .ref_pend(ref_pend), .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr),
        .sdram_bank(sdram_bank)
    );

    int tests = 0, fails = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model: who owns the bus ----------------
    bit m_valid = 0;
    int m_own, m_nxt, m_ticks;
    bit m_pend, m_aen, m_wen, m_ren, m_wrap;

    always @(posedge sclk) begin
        cyc++;
        if (s_rst) begin
            m_valid = 1; m_own = O_INIT; m_ticks = 0;
            m_pend = 0; m_aen = 0; m_wen = 0; m_ren = 0;
        end else if (m_valid) begin
            // refresh due once every RC enabled cycles, counted from reset
            m_wrap = init_done && (m_ticks % RC == RC - 1);
            if (init_done) m_ticks++;
            m_nxt = m_own;
            if (m_own == O_INIT && init_done) m_nxt = O_IDLE;
            if (m_own == O_IDLE) m_nxt = m_pend ? O_REF : wr_req ? O_WR : rd_req ? O_RD : O_IDLE;
            if (m_own == O_REF && aref_end) m_nxt = O_IDLE;
            if (m_own == O_WR  && wr_end)   m_nxt = O_IDLE;
            if (m_own == O_RD  && rd_end)   m_nxt = O_IDLE;
            m_aen = (m_nxt == O_REF) && (m_own != O_REF);
            m_wen = (m_nxt == O_WR)  && (m_own != O_WR);
            m_ren = (m_nxt == O_RD)  && (m_own != O_RD);
            if (m_aen) m_pend = 0;
            else if (m_wrap) m_pend = 1;
            m_own = m_nxt;
        end
    end

    // ---------------- compare process + grant log ----------------
    int grant_code[$], grant_t[$], aref_t[$];
    logic [18:0] eb;

    always @(negedge sclk) begin
        if (m_valid) begin
            case (m_own)
                O_INIT:  eb = {init_cmd, init_addr, 2'b00};
                O_IDLE:  eb = {4'b0111, 13'd0, 2'b00};
                O_REF:   eb = {aref_cmd, aref_addr, 2'b00};
                O_WR:    eb = {wr_cmd, wr_addr, wr_bank};
                default: eb = {rd_cmd, rd_addr, rd_bank};
            endcase
            chk("bus", {13'd0, sdram_cmd, sdram_addr, sdram_bank}, {13'd0, eb});
            chk("grants", {29'd0, aref_en, wr_en, rd_en}, {29'd0, m_aen, m_wen, m_ren});
            chk("ref_pend", {31'd0, ref_pend}, {31'd0, m_pend});
            if (aref_en) begin grant_code.push_back(O_REF); grant_t.push_back(cyc); aref_t.push_back(cyc); end
            if (wr_en)   begin grant_code.push_back(O_WR);  grant_t.push_back(cyc); end
            if (rd_en)   begin grant_code.push_back(O_RD);  grant_t.push_back(cyc); end
        end
    end

    // Refresh responder: aref_end sampled 10 cycles after aref_en.
    int aen_t = -100;
    always @(posedge sclk) begin
        #1;
        if (aref_en) aen_t = cyc;
        aref_end = (cyc == aen_t + 9);
    end

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    int g0, n0, rst_c;

    initial begin
        // reset and init
        repeat (3) tick();
        init_cmd = 4'b0010; tick();
        chk("rst_cmd_follows_init", {28'd0, sdram_cmd}, 32'h2);
        chk("rst_grants_low", {29'd0, aref_en, wr_en, rd_en}, 32'h0);
        init_cmd = 4'b0111; s_rst = 0; tick();
        init_done = 1; tick();
        chk("arbit_nop", {28'd0, sdram_cmd}, 32'h7);

        // single write
        wr_req = 1; wr_cmd = 4'b0100; wr_addr = 13'h123; wr_bank = 2'd2; tick(); wr_req = 0;
        chk("wr_en_first", {31'd0, wr_en}, 32'h1);
        chk("wr_bus", {13'd0, sdram_cmd, sdram_addr, sdram_bank}, {13'd0, 4'b0100, 13'h123, 2'd2});
        tick();
        chk("wr_en_one_cycle", {31'd0, wr_en}, 32'h0);
        wr_end = 1; tick(); wr_end = 0;
        chk("wr_end_nop", {28'd0, sdram_cmd}, 32'h7);

        // priority: hold a write until refresh is pending, then release with all requests up
        wr_req = 1; tick(); wr_req = 0;
        for (int i = 0; i < 1000 && !ref_pend; i++) tick();
        chk("pend_mid_wr", {31'd0, ref_pend}, 32'h1);
        wr_req = 1; rd_req = 1; wr_end = 1; tick(); wr_end = 0;
        g0 = grant_code.size();
        for (int i = 0; i < 40; i++) begin
            tick();
            wr_end = 0; rd_end = 0;
            if (wr_en) begin wr_req = 0; wr_end = 1; end
            if (rd_en) begin rd_req = 0; rd_end = 1; end
        end
        wr_end = 0; rd_end = 0;
        chk("prio_count", grant_code.size() - g0, 3);
        if (grant_code.size() >= g0 + 3) begin
            chk("prio_1st_aref", grant_code[g0], O_REF);
            chk("prio_2nd_wr", grant_code[g0+1], O_WR);
            chk("prio_3rd_rd", grant_code[g0+2], O_RD);
            chk("gap_aref_wr", grant_t[g0+1] - grant_t[g0], 11);
            chk("gap_wr_rd", grant_t[g0+2] - grant_t[g0+1], 2);
        end

        // refresh period with no traffic
        s_rst = 1; tick(); s_rst = 0; rst_c = cyc;
        aref_t.delete();
        repeat (3 * RC + 20) tick();
        chk("aref_count", aref_t.size(), 3);
        if (aref_t.size() >= 3) begin
            chk("aref_first", aref_t[0] - rst_c, RC + 1);
            chk("aref_period1", aref_t[1] - aref_t[0], RC);
            chk("aref_period2", aref_t[2] - aref_t[1], RC);
        end

        // refresh during a long write burst
        wr_req = 1; tick(); wr_req = 0;
        chk("long_wr_en", {31'd0, wr_en}, 32'h1);
        n0 = aref_t.size();
        repeat (2 * RC + 20) tick();
        chk("pend_held", {31'd0, ref_pend}, 32'h1);
        chk("no_aref_in_wr", aref_t.size(), n0);
        wr_end = 1; tick(); wr_end = 0; tick();
        chk("aref_after_wr", {31'd0, aref_en}, 32'h1);
        chk("pend_clr_on_aref", {31'd0, ref_pend}, 32'h0);
        repeat (12) tick();
        chk("single_aref", aref_t.size(), n0 + 1);

        // reset mid-read, stray rd_end afterwards
        rd_req = 1; tick(); rd_req = 0;
        chk("rd_en_first", {31'd0, rd_en}, 32'h1);
        tick(); s_rst = 1; init_cmd = 4'b0111; tick(); s_rst = 0;
        chk("rst_rd_en_low", {31'd0, rd_en}, 32'h0);
        chk("rst_rd_bus_init", {28'd0, sdram_cmd}, 32'h7);
        rd_end = 1; tick(); rd_end = 0;
        chk("stray_rd_end_nop", {28'd0, sdram_cmd}, 32'h7);
        tick();
        chk("stray_rd_end_no_grant", {29'd0, aref_en, wr_en, rd_en}, 32'h0);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            wr_req   = ($urandom % 3) == 0;
            rd_req   = ($urandom % 3) == 0;
            wr_end   = ($urandom % 6) == 0;
            rd_end   = ($urandom % 6) == 0;
            s_rst    = ($urandom % 500) == 0;
            init_cmd = 4'($urandom); init_addr = 13'($urandom);
            aref_cmd = 4'($urandom); aref_addr = 13'($urandom);
            wr_cmd = 4'($urandom); wr_addr = 13'($urandom); wr_bank = 2'($urandom);
            rd_cmd = 4'($urandom); rd_addr = 13'($urandom); rd_bank = 2'($urandom);
            tick();
        end
        wr_req = 0; rd_req = 0; wr_end = 0; rd_end = 0; s_rst = 0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sdram_arbit.md
# sdram_arbit

Command arbiter and sequencer for the SDRAM controller inside `sdram_top`. It owns the single SDRAM command/address bus and grants it in turn to the init, auto-refresh, write and read sub-modules, with fixed priority refresh > write > read. It runs the periodic refresh timer and tells an active burst to yield when a refresh is due. Runs in the 100 MHz SDRAM clock domain.

## Interface
- `REF_CYCLES`, 780: refresh interval in `sclk` cycles (64 ms / 8192 rows at 100 MHz).
- `CMD_NOP`, 4'b0111: idle command `{cs_n,ras_n,cas_n,we_n}`.
- `sclk` in 1: 100 MHz clock. One clock domain.
- `s_rst` in 1: reset, synchronous and active-high.
- `init_done` in 1: init sequence complete (level).
- `init_cmd` in 4, `init_addr` in 13: init command/address.
- `aref_en` out 1: start-refresh pulse.
- `aref_end` in 1: refresh done pulse.
- `aref_cmd` in 4, `aref_addr` in 13.
- `wr_req` in 1: write requester wants the bus (level).
- `wr_en` out 1: write grant pulse.
- `wr_end` in 1: write burst done pulse.
- `wr_cmd` in 4, `wr_addr` in 13, `wr_bank` in 2.
- `rd_req` in 1, `rd_en` out 1, `rd_end` in 1, `rd_cmd` in 4, `rd_addr` in 13, `rd_bank` in 2: read equivalents.
- `ref_pend` out 1: refresh is pending. The active writer or reader must finish its current burst and assert `*_end`.
- `sdram_cmd` out 4, `sdram_addr` out 13, `sdram_bank` out 2: muxed SDRAM bus.

## Operation
- States: INIT, ARBIT, AREF, WRITE, READ.
- INIT:
  - Bus = init_*.
  - Go to ARBIT on the cycle after `init_done` is first sampled high.
- ARBIT:
  - Bus = `CMD_NOP`, addr 0, bank 0.
  - Evaluated every cycle, in priority order:
    - `ref_pend` → AREF.
    - else `wr_req` → WRITE.
    - else `rd_req` → READ.
    - else stay in ARBIT.
- AREF / WRITE / READ:
  - Bus = that requester's cmd/addr/bank. `sdram_bank` = 0 in AREF.
  - Return to ARBIT on the cycle after the matching `*_end`.
  - `*_end` from a non-active requester is ignored.
- Grant pulses:
  - `aref_en`, `wr_en`, `rd_en` are registered.
  - Each is high for exactly one cycle: the first cycle spent in its state.
- Refresh timer:
  - Counter 0..REF_CYCLES-1, enabled only after `init_done`.
  - Wraps to 0 at REF_CYCLES-1 and sets `ref_pend`.
  - `ref_pend` clears on the cycle AREF is entered.
  - A wrap while already pending keeps `ref_pend` = 1. There is no refresh queue.
- `wr_req` / `rd_req` are sampled only in ARBIT. A request deasserted before it is sampled is lost, with no error.
- Bus mux is combinational from the state register. Mux inputs are trusted to be registered by the sub-modules.

## Timing
- Reset (sync, `s_rst`=1 at a rising edge):
  - State = INIT, timer = 0, `ref_pend` = 0.
  - `aref_en`, `wr_en`, `rd_en` = 0.
  - Bus shows init_* (`CMD_NOP` expected from the init block).
- Reset mid-burst: the same values apply on the next edge. No completion handshake is attempted.
- Arbitration latency: ARBIT seeing a request at edge N → granted state plus `*_en` at edge N+1.
- Turnaround: `*_end` at edge N → ARBIT at N+1 (one NOP cycle) → next grant at N+2 at the earliest.
- Simultaneous `ref_pend`, `wr_req`, `rd_req` in ARBIT: AREF wins. Write then precedes read.
- Timer wrap on the same cycle AREF is entered: the clear wins, so `ref_pend` = 0. That wrap is absorbed by the refresh now starting.

## Structure
- Shared package `sdram_pkg` holds:
  - command encodings (`CMD_NOP`, `CMD_AREF`, `CMD_PRE`, `CMD_ACT`, `CMD_WR`, `CMD_RD`, `CMD_MRS`);
  - the state enumeration (INIT=0, ARBIT=1, AREF=2, WRITE=3, READ=4, 3-bit);
  - the `REF_CYCLES` default.
- One sub-module: `sdram_ref_timer`. Inputs: `sclk`, `s_rst`, `init_done`, clear. Output: `ref_pend`.

## Test plan
- Reset and init:
  - `s_rst` held 3 cycles → all `*_en` = 0, `sdram_cmd` follows `init_cmd`.
  - `init_done` = 1 → ARBIT next cycle; `sdram_cmd` = 4'b0111.
- Single write:
  - `wr_req` = 1 in ARBIT → `wr_en` high exactly 1 cycle; bus = `wr_cmd`/`wr_addr`/`wr_bank`.
  - `wr_end` pulse → NOP next cycle.
- Priority:
  - `wr_req` = `rd_req` = 1 with `ref_pend` = 1 → grant order AREF, WRITE, READ.
  - Each grant is separated by one NOP cycle.
- Refresh period:
  - No traffic, REF_CYCLES = 780 → `aref_en` pulses every 780 cycles ±0 after the first.
  - `aref_end` returned 10 cycles after `aref_en`.
- Refresh during a long burst:
  - `ref_pend` rises mid-WRITE → stays 1.
  - Timer wrapping twice gives a single AREF after `wr_end`, and `ref_pend` clears on AREF entry.
- Reset mid-READ: `s_rst` pulse while in READ → INIT next edge, `rd_en` = 0, stray `rd_end` ignored.
